// File: rtl/raw8_pattern_generator.sv
// Synthetic RAW8 frame source with programmable timing and four test patterns.
// Optional macro RAW8_GEN_FRAME_CNT_EN stamps a completed-frame count into pixel (0,0).
module raw8_pattern_generator #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_FRONT   = 11'd10,
  parameter logic [10:0] V_LEAD    = 11'd2,
  parameter logic [10:0] V_TAIL    = 11'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_RAW,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    FRONT,
    LEAD,
    ACTIVE,
    TAIL
  } state_t;

  localparam logic [10:0] LINE_LEN = IMG_HDISP + H_BLANK;

  state_t      state;
  state_t      state_next;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic [1:0]  pat_q;
  logic        line_end;
  logic        frame_start;
  logic        frame_end;

  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  pix;
  logic        vsync_d;
  logic        href_d;
  logic [7:0]  raw_d;
  logic        done_d;

`ifdef RAW8_GEN_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  assign line_end = (hcnt == LINE_LEN - 11'd1);

  // Every state change happens on a line boundary; the end of a frame
  // either chains straight into the next FRONT or parks in IDLE.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next  = FRONT;
          frame_start = 1'b1;
        end
      end
      FRONT: begin
        if (line_end && vcnt == V_FRONT - 11'd1)
          state_next = (V_LEAD == 11'd0) ? ACTIVE : LEAD;
      end
      LEAD: begin
        if (line_end && vcnt == V_LEAD - 11'd1)
          state_next = ACTIVE;
      end
      ACTIVE: begin
        if (line_end && vcnt == IMG_VDISP - 11'd1) begin
          if (V_TAIL != 11'd0)
            state_next = TAIL;
          else
            frame_end = 1'b1;
        end
      end
      TAIL: begin
        if (line_end && vcnt == V_TAIL - 11'd1)
          frame_end = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (frame_end) begin
      if (enable) begin
        state_next  = FRONT;
        frame_start = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // vcnt counts lines within the current state, so it restarts on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= 11'd0;
      vcnt  <= 11'd0;
      pat_q <= 2'd0;
    end else if (frame_start) begin
      hcnt  <= 11'd0;
      vcnt  <= 11'd0;
      pat_q <= pattern_sel;
    end else if (state != IDLE) begin
      if (line_end) begin
        hcnt <= 11'd0;
        if (state_next != state)
          vcnt <= 11'd0;
        else
          vcnt <= vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  assign x = hcnt[7:0];
  assign y = vcnt[7:0];

  always_comb begin
    pix = 8'h00;
    case (pat_q)
      2'd0: pix = x;
      2'd1: pix = y;
      2'd2: pix = (x[3] ^ y[3]) ? 8'h00 : 8'hFF;
      default: begin
        case ({y[0], x[0]})
          2'b00:   pix = 8'hC0;
          2'b11:   pix = 8'h40;
          default: pix = 8'h80;
        endcase
      end
    endcase
`ifdef RAW8_GEN_FRAME_CNT_EN
    if (hcnt == 11'd0 && vcnt == 11'd0)
      pix = frame_cnt;
`endif
  end

  assign vsync_d = (state == LEAD) || (state == ACTIVE) || (state == TAIL);
  assign href_d  = (state == ACTIVE) && (hcnt < IMG_HDISP);
  assign raw_d   = href_d ? pix : 8'h00;
  // vsync only ever falls at the end of a frame, so its falling edge marks frame_done.
  assign done_d  = post_frame_vsync & ~vsync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_RAW     <= 8'h00;
      frame_done       <= 1'b0;
    end else begin
      post_frame_vsync <= vsync_d;
      post_frame_href  <= href_d;
      post_img_RAW     <= raw_d;
      frame_done       <= done_d;
    end
  end

`ifdef RAW8_GEN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= 8'h00;
    else if (done_d)
      frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/raw8_pattern_generator.md
Name: raw8_pattern_generator

Overview:
- Synthetic RAW8 video source that drives the codebase's per-frame stream interface: per_frame_vsync, per_frame_href and an 8-bit pixel.
- Acts as the transmitter for the image-processing pipeline input and replaces the CMOS sensor in simulation and on-board bring-up.
- Generates programmable frame/line timing and one of four test patterns, including a fixed RGGB Bayer flat field for checking RAW-to-RGB demosaic.

Parameters:
- IMG_HDISP, 11'd640: active pixels per line.
- IMG_VDISP, 11'd480: active lines per frame.
- H_BLANK, 11'd160: href-low cycles after each line's active pixels; must be ≥1.
- V_FRONT, 11'd10: lines with vsync low at frame start; must be ≥1.
- V_LEAD, 11'd2: lines with vsync high and href low before the first active line; may be 0.
- V_TAIL, 11'd2: lines with vsync high and href low after the last active line; may be 0.

Ports:
- clk, input, 1: pixel clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: run request, sampled only at frame boundaries.
- pattern_sel, input, 2: pattern select, latched at frame start.
- post_frame_vsync, output, 1: frame valid, active high.
- post_frame_href, output, 1: line valid, active high.
- post_img_RAW, output, 8: pixel data.
- frame_done, output, 1: one-cycle pulse at frame end.

Behaviour:
- Timing definitions:
  - Line length L = IMG_HDISP + H_BLANK cycles.
  - Frame = (V_FRONT + V_LEAD + IMG_VDISP + V_TAIL) lines; no gaps between frames while enable stays high.
  - Internal counters: hcnt 0..L-1, vcnt counting lines within the current state. hcnt wraps L-1 → 0 and increments the line count.
- FSM states IDLE, FRONT, LEAD, ACTIVE, TAIL:
  - IDLE → FRONT on the edge where enable = 1. That edge is the frame-start edge T0.
  - FRONT → LEAD after V_FRONT lines. If V_LEAD = 0, go directly to ACTIVE.
  - LEAD → ACTIVE after V_LEAD lines.
  - ACTIVE → TAIL after IMG_VDISP lines. If V_TAIL = 0, skip TAIL.
  - At the end of TAIL (end of frame): go to FRONT (new T0) if enable = 1, otherwise go to IDLE.
  - Deasserting enable mid-frame never truncates a frame.
- Frame start actions: hcnt, vcnt and the pixel coordinates x, y are cleared, and pattern_sel is latched. A change to pattern_sel mid-frame has no effect until the next frame.
- Outputs are all registered, with one clock of latency from the state/counter decode:
  - vsync = 1 in LEAD, ACTIVE and TAIL.
  - href = 1 in ACTIVE when hcnt < IMG_HDISP.
  - post_img_RAW = pattern(x, y) while href = 1, else 8'h00.
- Relative to T0, with every listed edge including that one-clock latency:
  - vsync rises after edge T0 + V_FRONT·L + 1.
  - The first href rises after edge T0 + (V_FRONT + V_LEAD)·L + 1.
- Patterns; x = active column 0..IMG_HDISP-1, y = active row 0..IMG_VDISP-1:
  - 0: horizontal ramp, x[7:0] (wraps modulo 256).
  - 1: vertical ramp, y[7:0].
  - 2: 8×8 checkerboard, 8'hFF when x[3] ^ y[3] = 0, else 8'h00.
  - 3: RGGB Bayer flat field: R (even y, even x) = 8'hC0; G (sites with x[0] ^ y[0] = 1) = 8'h80; B (odd y, odd x) = 8'h40.
- frame_done is high for exactly one cycle, coincident with the cycle in which output vsync falls (the first output cycle after the last TAIL line, or after the last ACTIVE line if V_TAIL = 0).
- Reset (asynchronous, any time, including mid-line):
  - State goes to IDLE; all counters and the latched pattern select are 0.
  - vsync = 0, href = 0, post_img_RAW = 8'h00, frame_done = 0.
  - After rst_n deasserts, generation restarts with a fresh frame on the first edge with enable = 1. There is no partial-frame resume.
- Counters are 11 bits wide; the parameter sums must fit in 11 bits.

Optional Feature:
- Macro RAW8_GEN_FRAME_CNT_EN.
- When defined:
  - An internal 8-bit frame counter resets to 0 and increments at every frame_done, wrapping 8'hFF → 8'h00.
  - Pixel (x = 0, y = 0) of each frame outputs the counter value (the count of frames completed before this one) instead of the pattern.
  - This allows dropped-frame detection downstream.
- When not defined: no counter exists, and pixel (0, 0) follows the selected pattern.

Test Plan:
All tests use small parameters: IMG_HDISP = 8, IMG_VDISP = 4, H_BLANK = 4, V_FRONT = 2, V_LEAD = 1, V_TAIL = 1, giving L = 12 and a frame of 96 cycles.
1. Timing, enable held high, pattern 0:
   - vsync high for 72 cycles per 96-cycle frame; 4 href pulses of 8 cycles each, spaced 12 cycles apart.
   - Pixels 00..07 on every line; frame_done pulses every 96 cycles, coincident with the vsync fall.
2. Pattern 3:
   - Line 0 outputs C0 80 C0 80 C0 80 C0 80; line 1 outputs 80 40 80 40 80 40 80 40.
   - post_img_RAW = 00 whenever href = 0.
3. pattern_sel changed 1 → 2 mid-ACTIVE:
   - The current frame continues the vertical ramp (00, 01, 02, 03 per line).
   - The next frame shows the checkerboard: all FF on lines 0..3, since y[3] = 0 and x < 8.
4. enable dropped during LEAD:
   - The frame completes all 4 active lines, frame_done pulses once, then outputs stay 0 in IDLE.
   - Re-asserting enable produces vsync rise 2·12 + 1 edges after T0.
5. rst_n asserted mid-href:
   - All outputs go to 0 immediately (asynchronous).
   - After release with enable = 1, a full frame restarts from FRONT.
6. RAW8_GEN_FRAME_CNT_EN defined, pattern 0, 3 frames:
   - Pixel (0, 0) reads 00, 01, 02 in successive frames; the other pixels are unchanged.
